// File: rtl/hangman_pkg.sv
// Shared constants for the hangman keyboard path: PS/2 set-2 scancodes,
// 5-bit key codes, the scan decoder FSM encoding and the scancode lookup.
package hangman_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;

  localparam logic [4:0] KEY_NONE  = 5'd0;
  localparam logic [4:0] KEY_A = 5'd1,  KEY_B = 5'd2,  KEY_C = 5'd3,  KEY_D = 5'd4;
  localparam logic [4:0] KEY_E = 5'd5,  KEY_F = 5'd6,  KEY_G = 5'd7,  KEY_H = 5'd8;
  localparam logic [4:0] KEY_I = 5'd9,  KEY_J = 5'd10, KEY_K = 5'd11, KEY_L = 5'd12;
  localparam logic [4:0] KEY_M = 5'd13, KEY_N = 5'd14, KEY_O = 5'd15, KEY_P = 5'd16;
  localparam logic [4:0] KEY_Q = 5'd17, KEY_R = 5'd18, KEY_S = 5'd19, KEY_T = 5'd20;
  localparam logic [4:0] KEY_U = 5'd21, KEY_V = 5'd22, KEY_W = 5'd23, KEY_X = 5'd24;
  localparam logic [4:0] KEY_Y = 5'd25, KEY_Z = 5'd26;
  localparam logic [4:0] KEY_ENTER = 5'd27;
  localparam logic [4:0] KEY_BKSP  = 5'd28;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } key_map_t;

  function automatic key_map_t scan_to_key(input logic [7:0] sc);
    key_map_t m;
    m.hit = 1'b1;
    case (sc)
      SC_A: m.code = KEY_A;  SC_B: m.code = KEY_B;  SC_C: m.code = KEY_C;
      SC_D: m.code = KEY_D;  SC_E: m.code = KEY_E;  SC_F: m.code = KEY_F;
      SC_G: m.code = KEY_G;  SC_H: m.code = KEY_H;  SC_I: m.code = KEY_I;
      SC_J: m.code = KEY_J;  SC_K: m.code = KEY_K;  SC_L: m.code = KEY_L;
      SC_M: m.code = KEY_M;  SC_N: m.code = KEY_N;  SC_O: m.code = KEY_O;
      SC_P: m.code = KEY_P;  SC_Q: m.code = KEY_Q;  SC_R: m.code = KEY_R;
      SC_S: m.code = KEY_S;  SC_T: m.code = KEY_T;  SC_U: m.code = KEY_U;
      SC_V: m.code = KEY_V;  SC_W: m.code = KEY_W;  SC_X: m.code = KEY_X;
      SC_Y: m.code = KEY_Y;  SC_Z: m.code = KEY_Z;
      SC_ENTER: m.code = KEY_ENTER;
      SC_BKSP:  m.code = KEY_BKSP;
      default: begin
        m.hit  = 1'b0;
        m.code = KEY_NONE;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through buffer for decoded key codes; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; empty masks dout, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/key_scan_decoder.sv
// PS/2 set-2 byte stream to buffered letter/Enter/Backspace key codes, with
// break/extended prefix handling and typematic-repeat suppression.
module key_scan_decoder
  import hangman_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] scan_byte,
  input  logic       scan_valid,
  output logic [4:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state;
  logic [7:0]    last_make;
  logic          pend_valid;
  logic [4:0]    pend_code;
  key_map_t      map;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;

  assign map       = scan_to_key(scan_byte);
  assign key_valid = (fifo_count != '0);
  assign fifo_pop  = key_ready && !fifo_empty;

  // NOTE: all state updates use <= so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state      <= ST_IDLE;
      last_make  <= 8'h00;
      pend_valid <= 1'b0;
      pend_code  <= KEY_NONE;
      overflow   <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      if (pend_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (scan_valid) begin
        case (state)
          ST_IDLE: begin
            if (scan_byte == SC_BREAK) begin
              state <= ST_BRK;
            end else if (scan_byte == SC_EXT) begin
              state <= ST_EXT;
            end else if (map.hit && scan_byte != last_make) begin
              pend_valid <= 1'b1;
              pend_code  <= map.code;
              last_make  <= scan_byte;
            end
          end
          ST_BRK: begin
            // Releasing the held key re-arms it; other releases are ignored.
            if (scan_byte == last_make) last_make <= 8'h00;
            state <= ST_IDLE;
          end
          ST_EXT:  state <= (scan_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (pend_valid),
    .pop    (fifo_pop),
    .din    (pend_code),
    .dout   (key_code),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_key_scan_decoder.sv
// Self-checking bench: directed scenarios plus random byte streams, compared
// each cycle against a queue-based keyboard model.
module tb_key_scan_decoder;

  localparam int DEPTH = 4;
  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] POOL [12] = '{
    8'h1C, 8'h32, 8'h21, 8'h15, 8'h1D, 8'h5A, 8'h66, 8'hF0, 8'hF0, 8'hE0, 8'h76, 8'h00};

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] scan_byte;
  logic       scan_valid;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [4:0] m_q [$];
  logic [7:0] m_last;
  bit         m_f0, m_e0, m_pend, m_ovf;
  logic [4:0] m_pend_code;

  always #5 clk = ~clk;

  key_scan_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .scan_byte  (scan_byte),
    .scan_valid (scan_valid),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .overflow   (overflow)
  );

  function automatic logic [4:0] ref_code(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (LETTERS[i] == b) return 5'(i + 1);
    if (b == 8'h5A) return 5'd27;
    if (b == 8'h66) return 5'd28;
    return 5'd0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge with the given pre-edge inputs.
  task automatic model_step(input bit rst, input bit vld, input logic [7:0] b, input bit rdy);
    bit was_full, popped;
    logic [4:0] c;
    if (rst) begin
      m_q.delete();
      m_last = 8'h00; m_f0 = 0; m_e0 = 0; m_pend = 0; m_ovf = 0;
      return;
    end
    was_full = (m_q.size() == DEPTH);
    popped   = (m_q.size() != 0) && rdy;
    if (popped) void'(m_q.pop_front());
    if (m_pend) begin
      if (was_full && !popped) m_ovf = 1;
      else m_q.push_back(m_pend_code);
    end
    m_pend = 0;
    if (!vld) return;
    if (m_e0) begin
      if (!m_f0 && b == 8'hF0) m_f0 = 1;
      else begin m_e0 = 0; m_f0 = 0; end
    end else if (m_f0) begin
      if (b == m_last) m_last = 8'h00;
      m_f0 = 0;
    end else if (b == 8'hF0) begin
      m_f0 = 1;
    end else if (b == 8'hE0) begin
      m_e0 = 1;
    end else begin
      c = ref_code(b);
      if (c != 0 && b != m_last) begin
        m_pend = 1; m_pend_code = c; m_last = b;
      end
    end
  endtask

  task automatic tick(input bit rst, input bit vld, input logic [7:0] b, input bit rdy);
    resetn = rst; scan_valid = vld; scan_byte = b; key_ready = rdy;
    @(posedge clk);
    model_step(rst, vld, b, rdy);
    #1;
    check("key_valid", 8'(key_valid), 8'(m_q.size() != 0));
    check("key_code", 8'(key_code), (m_q.size() != 0) ? 8'(m_q[0]) : 8'h00);
    check("overflow", 8'(overflow), 8'(m_ovf));
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    tick(1'b0, 1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 8'hF0, 1'b0);
  endtask

  initial begin
    resetn = 1'b1; scan_valid = 1'b0; scan_byte = 8'h00; key_ready = 1'b0;
    m_last = 8'h00; m_pend_code = 5'd0;

    // Reset state, with scan_valid asserted during reset.
    do_reset();
    do_reset();
    check("rst_key_valid", 8'(key_valid), 8'h00);
    check("rst_key_code", 8'(key_code), 8'h00);
    check("rst_overflow", 8'(overflow), 8'h00);

    // 1C F0 1C with consumer ready: one entry, two-edge latency.
    send(8'h1C, 1'b1);
    check("lat_edge1", 8'(key_valid), 8'h00);
    idle(1, 1'b1);
    check("lat_edge2", 8'(key_valid), 8'h01);
    check("lat_code", 8'(key_code), 8'h01);
    send(8'hF0, 1'b1);
    check("lat_popped", 8'(key_valid), 8'h00);
    send(8'h1C, 1'b1);
    idle(3, 1'b1);
    check("lat_empty", 8'(key_valid), 8'h00);

    // Typematic repeat, then re-press after break.
    do_reset();
    foreach (POOL[i]) if (i < 0) send(POOL[i], 1'b1);
    send(8'h1C, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
    idle(3, 1'b1);

    // Extended sequences dropped, plain Enter kept, Esc ignored.
    do_reset();
    send(8'hE0, 1'b0); send(8'h5A, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h5A, 1'b0);
    send(8'h5A, 1'b0); send(8'h76, 1'b0);
    idle(2, 1'b0);
    check("ext_head", 8'(key_code), 8'd27);
    idle(1, 1'b1);
    check("ext_only_one", 8'(key_valid), 8'h00);

    // Overflow: Q W E R T with breaks, consumer stalled.
    do_reset();
    send(8'h15, 1'b0); send(8'hF0, 1'b0); send(8'h15, 1'b0);
    send(8'h1D, 1'b0); send(8'hF0, 1'b0); send(8'h1D, 1'b0);
    send(8'h24, 1'b0); send(8'hF0, 1'b0); send(8'h24, 1'b0);
    send(8'h2D, 1'b0); send(8'hF0, 1'b0); send(8'h2D, 1'b0);
    send(8'h2C, 1'b0); send(8'hF0, 1'b0); send(8'h2C, 1'b0);
    idle(2, 1'b0);
    check("ovf_flag", 8'(overflow), 8'h01);
    check("ovf_head", 8'(key_code), 8'd17);
    check("ovf_pop0", 8'(key_code), 8'd17); idle(1, 1'b1);
    check("ovf_pop1", 8'(key_code), 8'd23); idle(1, 1'b1);
    check("ovf_pop2", 8'(key_code), 8'd5);  idle(1, 1'b1);
    check("ovf_pop3", 8'(key_code), 8'd18); idle(1, 1'b1);
    check("ovf_drained", 8'(key_valid), 8'h00);

    // Full FIFO: push and pop on the same edge.
    do_reset();
    send(8'h1C, 1'b0); send(8'h32, 1'b0); send(8'h21, 1'b0); send(8'h23, 1'b0);
    idle(2, 1'b0);
    send(8'h35, 1'b0);
    idle(1, 1'b1);
    check("pp_no_ovf", 8'(overflow), 8'h00);
    check("pp_head", 8'(key_code), 8'd2);  idle(1, 1'b1);
    check("pp_q1", 8'(key_code), 8'd3);    idle(1, 1'b1);
    check("pp_q2", 8'(key_code), 8'd4);    idle(1, 1'b1);
    check("pp_tail", 8'(key_code), 8'd25); idle(1, 1'b1);
    check("pp_empty", 8'(key_valid), 8'h00);

    // Reset between F0 and its break byte.
    do_reset();
    send(8'hF0, 1'b0);
    do_reset();
    send(8'h1C, 1'b0);
    idle(2, 1'b0);
    check("midrst_code", 8'(key_code), 8'd1);
    check("midrst_ovf", 8'(overflow), 8'h00);

    // Random streams against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      b = POOL[$urandom_range(11)];
      if (b == 8'h00) b = 8'($urandom);
      if ($urandom_range(199) == 0) do_reset();
      else tick(1'b0, $urandom_range(9) < 6, b, $urandom_range(9) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_scan_decoder.md
KEY_SCAN_DECODER -- requirements
Module: key_scan_decoder

Interface
REQ-001 SHALL take parameter FIFO_DEPTH, default 4, meaning the number of decoded key entries buffered; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port scan_byte, input, 8 bits: a PS/2 set-2 byte from the receiver.
REQ-005 SHALL have port scan_valid, input, 1 bit: one-cycle strobe marking scan_byte valid.
REQ-006 SHALL have port key_code, output, 5 bits: the FIFO head entry. Encoding: 1-26 = A-Z, 27 = Enter, 28 = Backspace, 0 = none. Feeds the datapath char/guess input.
REQ-007 SHALL have port key_valid, output, 1 bit: FIFO not empty.
REQ-008 SHALL have port key_ready, input, 1 bit: consumer accept.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag; a decoded key was dropped.

Function
REQ-010 SHALL run an FSM with states IDLE, BRK (F0 seen), EXT (E0 seen) and EXT_BRK (E0 F0 seen); a byte is consumed only when scan_valid=1.
REQ-011 SHALL use these transitions: IDLE+F0->BRK; IDLE+E0->EXT; EXT+F0->EXT_BRK; BRK/EXT/EXT_BRK + any other byte -> IDLE; IDLE + other byte -> IDLE, with the byte treated as a make code.
REQ-012 SHALL discard bytes completing EXT or EXT_BRK (extended keys are unsupported), including E0 5A.
REQ-013 SHALL map make codes in IDLE through the set-2 table: A=1C ... Z=1A, Enter=5A, Backspace=66. Unmapped codes produce no entry and no error.
REQ-014 SHALL suppress typematic repeat: hold last_make (8 bits, 00 = none). A mapped make equal to last_make is dropped; otherwise it is pushed and last_make is loaded.
REQ-015 SHALL clear last_make to 00 on a break byte (BRK) equal to last_make; a break of any other code leaves last_make unchanged.
REQ-016 SHALL register the decode at the edge that consumes the make byte and push at the following edge. key_valid is high in the cycle after that push when the FIFO was empty: two-edge latency.
REQ-017 SHALL pop on key_valid & key_ready at the clock edge. key_code is the head entry, first-word-fall-through, and is stable while key_valid=1 and key_ready=0.
REQ-018 SHALL drive key_code=0 when the FIFO is empty.
REQ-019 SHALL accept a push and a pop in the same cycle with the FIFO full and no overflow. The count is unchanged.
REQ-020 SHALL drop the new entry on a push with the FIFO full and no pop, set overflow=1, and leave the FIFO contents untouched.
REQ-021 SHALL keep pointers at log2(FIFO_DEPTH) bits wrapping modulo depth, with a count of log2(FIFO_DEPTH)+1 bits; full is count==FIFO_DEPTH, empty is count==0.
REQ-022 SHALL keep decoding at most one byte per cycle; back-to-back scan_valid on consecutive cycles SHALL be handled without loss.

Reset
REQ-023 SHALL, with resetn=1 at an edge: FSM to IDLE, last_make to 00, pending decode cleared, FIFO emptied, overflow to 0, key_valid to 0, key_code to 0.
REQ-024 SHALL, on reset mid-sequence (e.g. after F0), ignore the following byte's break meaning; it is decoded from IDLE.
REQ-025 SHALL ignore scan_valid in the reset cycle.

Structure
REQ-026 SHALL place scancode constants, the 5-bit key code constants (KEY_NONE, KEY_A..KEY_Z, KEY_ENTER, KEY_BKSP) and the FSM state encoding in shared package hangman_pkg.
REQ-027 SHALL implement the buffer as a sub-module key_fifo (parameterized depth, 5-bit width, FWFT, push/pop/full/empty/count).
REQ-028 SHALL contain no combinational path from scan_byte/scan_valid to any output.

Verification
REQ-029 SHALL cover this scenario: bytes 1C, F0, 1C with key_ready=1 -> exactly one entry key_code=1, key_valid high the second cycle after 1C is accepted, then empty.
REQ-030 SHALL cover this scenario: typematic 1C,1C,1C,F0,1C,1C -> two entries of code 1, since the second press follows the break.
REQ-031 SHALL cover this scenario: E0 5A, E0 F0 5A, then 5A -> one entry code 27 only; 76 (Esc) -> no entry.
REQ-032 SHALL cover this scenario: key_ready=0, FIFO_DEPTH=4, distinct makes Q,W,E,R,T with breaks between -> head=17, count 4, T dropped, overflow=1; then pop all -> 17,23,5,18.
REQ-033 SHALL cover this scenario: FIFO full, a push and pop in the same cycle -> no overflow, count stays 4, new code at the tail.
REQ-034 SHALL cover this scenario: F0 accepted, then resetn pulse, then 1C -> entry code 1 and overflow=0.
